// File: rtl/stack_pkg.sv
// Shared types and defaults for the downward-growing hardware stack controller.
// Consumers: stack_ctrl (optional PEEK support under STACK_PEEK_EN) and stack_sp_reg.
package stack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    FIN
  } state_e;

  localparam logic [15:0] SP_TOP_DEFAULT      = 16'h01FF;
  localparam int          STACK_DEPTH_DEFAULT = 256;

endpackage

// File: rtl/stack_sp_reg.sv
// Stack pointer register with single-step inc/dec and the occupancy compares.
// EMPTY sits at SP_TOP; FULL sits DEPTH words below it.
module stack_sp_reg
  import stack_pkg::*;
#(
  parameter logic [15:0] SP_TOP = SP_TOP_DEFAULT,
  parameter int          DEPTH  = STACK_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        dec_i,
  output logic [15:0] sp_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam logic [15:0] FullSp = SP_TOP - 16'(DEPTH);

  logic [15:0] sp_q, sp_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sp_q <= SP_TOP;
    else       sp_q <= sp_d;
  end

  always_comb begin
    sp_d = sp_q;
    if (inc_i)      sp_d = sp_q + 16'd1;
    else if (dec_i) sp_d = sp_q - 16'd1;
  end

  assign sp_o    = sp_q;
  assign empty_o = (sp_q == SP_TOP);
  assign full_o  = (sp_q == FullSp);

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: sequences push (WR) and pop (RD/CAP) accesses to an external memory.
// Define STACK_PEEK_EN to add the PEEK port (read top of stack without popping).
module stack_ctrl
  import stack_pkg::*;
#(
  parameter logic [15:0] SP_TOP = SP_TOP_DEFAULT,
  parameter int          DEPTH  = STACK_DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PUSH,
  input  logic        POP,
`ifdef STACK_PEEK_EN
  input  logic        PEEK,
`endif
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        FULL,
  output logic        EMPTY,
  output logic [15:0] SP,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic        MEM_RE,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA
);

  state_e      state_q, state_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic        sp_inc, sp_dec;
  logic        err_c;
  logic        conflict;
`ifdef STACK_PEEK_EN
  logic        peek_q, peek_d;
`endif

  stack_sp_reg #(
    .SP_TOP (SP_TOP),
    .DEPTH  (DEPTH)
  ) u_sp (
    .clk_i   (CLK),
    .rst_i   (RST),
    .inc_i   (sp_inc),
    .dec_i   (sp_dec),
    .sp_o    (SP),
    .full_o  (FULL),
    .empty_o (EMPTY)
  );

`ifdef STACK_PEEK_EN
  assign conflict = (PUSH && POP) || (PEEK && (PUSH || POP));
`else
  assign conflict = PUSH && POP;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      wdata_q <= '0;
      dout_q  <= '0;
`ifdef STACK_PEEK_EN
      peek_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
`ifdef STACK_PEEK_EN
      peek_q  <= peek_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
`ifdef STACK_PEEK_EN
    peek_d   = peek_q;
`endif
    sp_inc   = 1'b0;
    sp_dec   = 1'b0;
    MEM_WE   = 1'b0;
    MEM_RE   = 1'b0;
    MEM_ADDR = SP;
    DONE     = 1'b0;
    err_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (conflict) begin
          err_c = 1'b1;
        end else if (PUSH) begin
          if (FULL) err_c = 1'b1;
          else begin
            wdata_d = DIN;
            state_d = WR;
          end
        end else if (POP) begin
          if (EMPTY) err_c = 1'b1;
          else begin
            state_d = RD;
`ifdef STACK_PEEK_EN
            peek_d  = 1'b0;
`endif
          end
`ifdef STACK_PEEK_EN
        end else if (PEEK) begin
          if (EMPTY) err_c = 1'b1;
          else begin
            state_d = RD;
            peek_d  = 1'b1;
          end
`endif
        end
      end
      WR: begin
        MEM_WE  = 1'b1;
        sp_dec  = 1'b1;
        state_d = FIN;
      end
      RD: begin
        MEM_RE   = 1'b1;
        MEM_ADDR = SP + 16'd1;
        state_d  = CAP;
      end
      CAP: begin
        // Read data returns one cycle after the RD strobe, so it is captured here.
        dout_d  = MEM_RDATA;
`ifdef STACK_PEEK_EN
        sp_inc  = !peek_q;
`else
        sp_inc  = 1'b1;
`endif
        state_d = FIN;
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ERR is decoded straight from the request pins, so it is masked while reset is held.
  assign ERR       = err_c && !RST;
  assign BUSY      = (state_q != IDLE);
  assign DOUT      = dout_q;
  assign MEM_WDATA = wdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a registered-read memory model.
// Define STACK_PEEK_EN to also exercise the PEEK feature.
module tb_stack_ctrl;

  logic        CLK, RST, PUSH, POP;
  logic [15:0] DIN;
  logic [15:0] DOUT, SP, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        BUSY, DONE, ERR, FULL, EMPTY, MEM_WE, MEM_RE;
`ifdef STACK_PEEK_EN
  logic        PEEK;
`endif

  logic [15:0] mem [0:511];
  int total, bad;

  stack_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .PUSH      (PUSH),
    .POP       (POP),
`ifdef STACK_PEEK_EN
    .PEEK      (PEEK),
`endif
    .DIN       (DIN),
    .DOUT      (DOUT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .SP        (SP),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WE    (MEM_WE),
    .MEM_RE    (MEM_RE),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR[8:0]] <= MEM_WDATA;
    if (MEM_RE) MEM_RDATA <= mem[MEM_ADDR[8:0]];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Cycles are counted from the accept edge; -1 means DONE never arrived.
  task automatic run_push(input logic [15:0] d, output int lat);
    PUSH = 1'b1;
    DIN  = d;
    tick();
    PUSH = 1'b0;
    lat  = -1;
    for (int c = 1; c <= 8; c++) begin
      if (DONE === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic run_pop(output logic [15:0] q, output int lat);
    POP = 1'b1;
    tick();
    POP = 1'b0;
    lat = -1;
    q   = 16'hxxxx;
    for (int c = 1; c <= 8; c++) begin
      if (DONE === 1'b1) begin
        lat = c;
        q   = DOUT;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset;
    RST = 1'b1;
    #2;
    total++; if (SP !== 16'h01FF) begin bad++; $display("[TB] FAIL reset_sp: got %h want 01ff", SP); end
    total++; if (EMPTY !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", EMPTY); end
    total++; if (FULL !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", FULL); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", BUSY); end
    total++; if (DOUT !== 16'h0000) begin bad++; $display("[TB] FAIL reset_dout: got %h want 0000", DOUT); end
    total++;
    if ({DONE, ERR, MEM_WE, MEM_RE} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_strobes: got %b want 0000", {DONE, ERR, MEM_WE, MEM_RE});
    end
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_push_pop;
    PUSH = 1'b1;
    DIN  = 16'hA5A5;
    tick();
    PUSH = 1'b0;
    total++; if (MEM_WE !== 1'b1) begin bad++; $display("[TB] FAIL pp_wr_we: got %b want 1", MEM_WE); end
    total++; if (MEM_ADDR !== 16'h01FF) begin bad++; $display("[TB] FAIL pp_wr_addr: got %h want 01ff", MEM_ADDR); end
    total++; if (MEM_WDATA !== 16'hA5A5) begin bad++; $display("[TB] FAIL pp_wr_data: got %h want a5a5", MEM_WDATA); end
    total++; if (DONE !== 1'b0) begin bad++; $display("[TB] FAIL pp_push_early_done: got %b want 0", DONE); end
    tick();
    total++; if (DONE !== 1'b1) begin bad++; $display("[TB] FAIL pp_push_done: got %b want 1", DONE); end
    total++; if (SP !== 16'h01FE) begin bad++; $display("[TB] FAIL pp_push_sp: got %h want 01fe", SP); end
    tick();
    total++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("[TB] FAIL pp_push_idle: done=%b busy=%b want 0 0", DONE, BUSY); end
    POP = 1'b1;
    tick();
    POP = 1'b0;
    total++; if (MEM_RE !== 1'b1) begin bad++; $display("[TB] FAIL pp_rd_re: got %b want 1", MEM_RE); end
    total++; if (MEM_ADDR !== 16'h01FF) begin bad++; $display("[TB] FAIL pp_rd_addr: got %h want 01ff", MEM_ADDR); end
    tick();
    total++; if (DONE !== 1'b0 || MEM_RE !== 1'b0) begin bad++; $display("[TB] FAIL pp_cap: done=%b re=%b want 0 0", DONE, MEM_RE); end
    tick();
    total++; if (DONE !== 1'b1) begin bad++; $display("[TB] FAIL pp_pop_done: got %b want 1", DONE); end
    total++; if (DOUT !== 16'hA5A5) begin bad++; $display("[TB] FAIL pp_pop_dout: got %h want a5a5", DOUT); end
    total++; if (SP !== 16'h01FF) begin bad++; $display("[TB] FAIL pp_pop_sp: got %h want 01ff", SP); end
    tick();
  endtask

  task automatic test_pop_empty;
    POP = 1'b1;
    #1;
    total++; if (ERR !== 1'b1) begin bad++; $display("[TB] FAIL pe_err: got %b want 1", ERR); end
    tick();
    POP = 1'b0;
    #1;
    total++; if (MEM_RE !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("[TB] FAIL pe_noop: re=%b busy=%b want 0 0", MEM_RE, BUSY); end
    total++; if (SP !== 16'h01FF) begin bad++; $display("[TB] FAIL pe_sp: got %h want 01ff", SP); end
    total++; if (ERR !== 1'b0) begin bad++; $display("[TB] FAIL pe_err_clear: got %b want 0", ERR); end
  endtask

  task automatic test_errors;
    int lat, dones;
    run_push(16'h0042, lat);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL er_push_lat: got %0d want 2", lat); end
    PUSH = 1'b1;
    POP  = 1'b1;
    #1;
    total++; if (ERR !== 1'b1) begin bad++; $display("[TB] FAIL er_both_err: got %b want 1", ERR); end
    tick();
    PUSH = 1'b0;
    POP  = 1'b0;
    total++; if (SP !== 16'h01FE || BUSY !== 1'b0) begin bad++; $display("[TB] FAIL er_both_noop: sp=%h busy=%b want 01fe 0", SP, BUSY); end
    dones = 0;
    PUSH = 1'b1;
    DIN  = 16'h0077;
    tick();
    total++; if (ERR !== 1'b0) begin bad++; $display("[TB] FAIL er_busy_err_wr: got %b want 0", ERR); end
    dones += int'(DONE);
    tick();
    total++; if (ERR !== 1'b0) begin bad++; $display("[TB] FAIL er_busy_err_fin: got %b want 0", ERR); end
    dones += int'(DONE);
    PUSH = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      dones += int'(DONE);
    end
    total++; if (dones !== 1) begin bad++; $display("[TB] FAIL er_busy_done_count: got %0d want 1", dones); end
    total++; if (SP !== 16'h01FD) begin bad++; $display("[TB] FAIL er_busy_sp: got %h want 01fd", SP); end
  endtask

  task automatic test_reset_mid;
    int lat, dones;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    run_push(16'h5555, lat);
    POP = 1'b1;
    tick();
    POP = 1'b0;
    tick();
    total++; if (BUSY !== 1'b1 || MEM_RE !== 1'b0) begin bad++; $display("[TB] FAIL rm_in_cap: busy=%b re=%b want 1 0", BUSY, MEM_RE); end
    RST = 1'b1;
    #1;
    total++; if (SP !== 16'h01FF) begin bad++; $display("[TB] FAIL rm_sp: got %h want 01ff", SP); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("[TB] FAIL rm_idle: busy=%b done=%b want 0 0", BUSY, DONE); end
    total++; if (DOUT !== 16'h0000) begin bad++; $display("[TB] FAIL rm_dout: got %h want 0000", DOUT); end
    tick();
    RST = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      dones += int'(DONE);
    end
    total++; if (dones !== 0) begin bad++; $display("[TB] FAIL rm_no_done: got %0d want 0", dones); end
  endtask

  task automatic test_fill;
    int lat;
    logic [15:0] q;
    for (int i = 0; i < 256; i++) begin
      run_push(16'(i), lat);
      if (lat !== 2) begin
        total++; bad++;
        $display("[TB] FAIL fill_push_lat: idx=%0d got %0d want 2", i, lat);
      end
    end
    total++; if (FULL !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got %b want 1", FULL); end
    total++; if (SP !== 16'h00FF) begin bad++; $display("[TB] FAIL fill_sp: got %h want 00ff", SP); end
    PUSH = 1'b1;
    DIN  = 16'hDEAD;
    #1;
    total++; if (ERR !== 1'b1) begin bad++; $display("[TB] FAIL fill_overflow_err: got %b want 1", ERR); end
    tick();
    PUSH = 1'b0;
    total++; if (MEM_WE !== 1'b0 || BUSY !== 1'b0 || SP !== 16'h00FF) begin
      bad++; $display("[TB] FAIL fill_overflow_noop: we=%b busy=%b sp=%h want 0 0 00ff", MEM_WE, BUSY, SP);
    end
    for (int i = 255; i >= 0; i--) begin
      run_pop(q, lat);
      total++;
      if (q !== 16'(i) || lat !== 3) begin
        bad++; $display("[TB] FAIL fill_pop: got %h lat %0d want %h lat 3", q, lat, 16'(i));
      end
    end
    total++; if (EMPTY !== 1'b1 || SP !== 16'h01FF) begin bad++; $display("[TB] FAIL fill_drained: empty=%b sp=%h want 1 01ff", EMPTY, SP); end
  endtask

`ifdef STACK_PEEK_EN
  task automatic test_peek;
    int lat;
    run_push(16'h1234, lat);
    PEEK = 1'b1;
    tick();
    PEEK = 1'b0;
    total++; if (MEM_RE !== 1'b1 || MEM_ADDR !== 16'h01FF) begin bad++; $display("[TB] FAIL pk_rd: re=%b addr=%h want 1 01ff", MEM_RE, MEM_ADDR); end
    tick();
    tick();
    total++; if (DONE !== 1'b1) begin bad++; $display("[TB] FAIL pk_done: got %b want 1", DONE); end
    total++; if (DOUT !== 16'h1234) begin bad++; $display("[TB] FAIL pk_dout: got %h want 1234", DOUT); end
    total++; if (SP !== 16'h01FE) begin bad++; $display("[TB] FAIL pk_sp: got %h want 01fe", SP); end
    tick();
    PEEK = 1'b1;
    PUSH = 1'b1;
    #1;
    total++; if (ERR !== 1'b1) begin bad++; $display("[TB] FAIL pk_conflict_err: got %b want 1", ERR); end
    tick();
    PEEK = 1'b0;
    PUSH = 1'b0;
    total++; if (BUSY !== 1'b0 || SP !== 16'h01FE) begin bad++; $display("[TB] FAIL pk_conflict_noop: busy=%b sp=%h want 0 01fe", BUSY, SP); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b0;
    PUSH  = 1'b0;
    POP   = 1'b0;
    DIN   = 16'h0000;
`ifdef STACK_PEEK_EN
    PEEK  = 1'b0;
`endif
    test_reset();
    test_push_pop();
    test_pop_empty();
    test_errors();
    test_reset_mid();
    test_fill();
`ifdef STACK_PEEK_EN
    test_peek();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter SP_TOP, default 16'h01FF, initial stack pointer and empty-stack address; the stack grows downward.
REQ-002 Parameter DEPTH, default 256, maximum number of stored words.
REQ-003 Port CLK  input  1  single clock; all state changes occur on the rising edge.
REQ-004 Port RST  input  1  reset, asynchronous and active-high.
REQ-005 Port PUSH  input  1  push request, sampled in IDLE only.
REQ-006 Port POP  input  1  pop request, sampled in IDLE only.
REQ-007 Port DIN  input  16  push data, captured on the accept edge.
REQ-008 Port DOUT  output  16  last popped (or peeked) word; holds between operations.
REQ-009 Port BUSY  output  1  high in every state except IDLE.
REQ-010 Port DONE  output  1  one-cycle pulse marking completion of an operation.
REQ-011 Port ERR  output  1  one-cycle pulse marking a rejected request.
REQ-012 Port FULL / EMPTY  output  1 each  stack-occupancy flags.
REQ-013 Port SP  output  16  current stack pointer.
REQ-014 Port MEM_ADDR  output  16 / MEM_WE  output  1 / MEM_RE  output  1 / MEM_WDATA  output  16  memory-side drive signals.
REQ-015 Port MEM_RDATA  input  16  memory read data, valid exactly one cycle after the MEM_RE cycle.

Function
REQ-016 FSM states SHALL be IDLE, WR, RD, CAP, FIN.
REQ-017 Push accepted in IDLE (PUSH=1, POP=0, !FULL): DIN registered; next state WR.
REQ-018 In WR: MEM_WE=1, MEM_ADDR=SP, MEM_WDATA=registered DIN; SP decrements by 1 on exit; next state FIN.
REQ-019 Pop accepted in IDLE (POP=1, PUSH=0, !EMPTY): next state RD.
REQ-020 In RD: MEM_RE=1, MEM_ADDR=SP+1; next state CAP.
REQ-021 In CAP: DOUT loads MEM_RDATA and SP increments by 1; next state FIN.
REQ-022 In FIN: DONE=1 for one cycle; next state IDLE. Push latency is 2 cycles from the accept edge to DONE; pop latency is 3 cycles.
REQ-023 EMPTY=1 iff SP==SP_TOP; FULL=1 iff SP==SP_TOP-DEPTH. Both flags are combinational from SP.
REQ-024 Rejected request in IDLE:
- Push while FULL, pop while EMPTY, or PUSH and POP both high: ERR=1 for that cycle.
- No memory access, SP unchanged, state stays IDLE.
REQ-025 PUSH and POP are ignored while BUSY: no queuing and no ERR.
REQ-026 MEM_WE, MEM_RE, DONE and ERR SHALL be 0 in every state not listed for them.
REQ-027 SP arithmetic is 16-bit and never wraps; REQ-024 prevents stepping past FULL or EMPTY.

Reset
REQ-028 Asserting RST forces, immediately and independently of CLK:
- state = IDLE, SP = SP_TOP, DOUT = 0;
- DONE, ERR, MEM_WE, MEM_RE = 0.
REQ-029 RST mid-operation aborts the operation: no DONE is produced, SP returns to SP_TOP, and any memory write not yet clocked is lost.

Configuration
REQ-030 Macro STACK_PEEK_EN defined: adds input port PEEK (1 bit).
- PEEK=1 with PUSH=0, POP=0, !EMPTY in IDLE runs RD -> CAP -> FIN with SP unchanged in CAP.
- PEEK while EMPTY, or PEEK together with PUSH or POP: ERR=1, no operation.
REQ-031 Macro undefined: no PEEK port and no peek logic.

Structure
REQ-032 Shared package stack_pkg holds:
- the FSM state encoding;
- constants SP_TOP_DEFAULT = 16'h01FF and STACK_DEPTH_DEFAULT = 256.
REQ-033 One sub-module, stack_sp_reg: the 16-bit pointer register with reset value SP_TOP, inc/dec inputs and the FULL/EMPTY compare. The FSM and memory sequencing stay in stack_ctrl.

Verification
REQ-034 Reset: RST=1 -> SP=16'h01FF, EMPTY=1, FULL=0, BUSY=0, DOUT=0.
REQ-035 Push then pop:
- push DIN=16'hA5A5 -> WR cycle shows MEM_WE=1, MEM_ADDR=16'h01FF; DONE two cycles after accept; SP=16'h01FE.
- pop -> MEM_RE=1 with MEM_ADDR=16'h01FF; DOUT=16'hA5A5; SP=16'h01FF; DONE three cycles after accept.
REQ-036 Pop while EMPTY -> ERR pulse, no MEM_RE, SP stays 16'h01FF.
REQ-037 Fill: 256 pushes of values 0..255 -> FULL=1 and SP=16'h00FF; 257th push -> ERR, no MEM_WE; then 256 pops return values 255..0 in order.
REQ-038 Error and ignore cases:
- PUSH=POP=1 in IDLE -> ERR, SP unchanged.
- PUSH pulsed while BUSY -> ignored: no ERR, exactly one DONE.
REQ-039 Reset mid-operation: RST asserted in CAP -> no DONE, SP=16'h01FF. With STACK_PEEK_EN defined, PEEK after one push of 16'h1234 -> DOUT=16'h1234 and SP remains 16'h01FE.
